// File: rtl/pid_mixer_sequencer_pkg.sv
// Shared definitions for the PID mixer sequencer: FSM states, mix geometry
// and the per-motor add/subtract sign table.
package pid_mixer_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_IDLE     = 3'd1,
    ST_MIX      = 3'd2,
    ST_PUBLISH  = 3'd3,
    ST_FAULT    = 3'd4
  } mix_state_t;

  localparam int MIX_TERMS  = 4;
  localparam int NUM_MOTORS = 4;

  // Sign table indexed [motor][term-1]; bit set means subtract.
  // Term order after throttle is yaw (bit0), roll (bit1), pitch (bit2).
  //   m1 = T - Y + R + P
  //   m2 = T + Y - R + P
  //   m3 = T - Y - R - P
  //   m4 = T + Y + R - P
  localparam logic [NUM_MOTORS-1:0][MIX_TERMS-2:0] SIGN_TABLE =
    {3'b100, 3'b111, 3'b010, 3'b001};

  // States in which the motors may be driven and the watchdog runs.
  function automatic logic is_armed_state(input mix_state_t s);
    return (s == ST_IDLE) || (s == ST_MIX) || (s == ST_PUBLISH);
  endfunction

endpackage

// File: rtl/pid_mixer_sequencer_addsub_clamp.sv
// Shared arithmetic unit: registered accumulator with load/add/subtract
// control and a combinational clamp to the motor output range.
module mixer_addsub_clamp #(
  parameter int RBW       = 36,
  parameter int MBW       = 16,
  parameter int MOTOR_MIN = 0,
  parameter int MOTOR_MAX = 1000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_en,
  input  logic           i_load,
  input  logic           i_sub,
  input  logic [RBW-1:0] i_operand,
  output logic [MBW-1:0] o_clamped
);

  // Two guard bits: four RBW-bit terms cannot overflow RBW+2 bits.
  localparam int AW = RBW + 2;
  localparam logic signed [AW-1:0] MIN_S = AW'(MOTOR_MIN);
  localparam logic signed [AW-1:0] MAX_S = AW'(MOTOR_MAX);

  logic signed [AW-1:0] r_acc;
  logic signed [AW-1:0] w_ext;
  logic signed [AW-1:0] w_next;

  function automatic logic [MBW-1:0] clamp_f(input logic signed [AW-1:0] a);
    logic [MBW-1:0] res;
    if (a < MIN_S) begin
      res = MBW'(MOTOR_MIN);
    end else if (a > MAX_S) begin
      res = MBW'(MOTOR_MAX);
    end else begin
      res = a[MBW-1:0];
    end
    return res;
  endfunction

  // Adder/subtractor and clamp; the clamp follows the adder so the final
  // term of a motor can be staged on the same edge it is accumulated.
  always_comb begin
    w_ext = {{2{i_operand[RBW-1]}}, i_operand};
    if (i_load) begin
      w_next = w_ext;
    end else if (i_sub) begin
      w_next = r_acc - w_ext;
    end else begin
      w_next = r_acc + w_ext;
    end
    o_clamped = clamp_f(w_next);
  end

  // Accumulator register, advanced only while the sequencer drives the unit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_next;
    end else begin
      r_acc <= r_acc;
    end
  end

endmodule

// File: rtl/pid_mixer_sequencer.sv
// Time-multiplexed quad mixer between the PID stage and the motor drivers.
// Captures one T/Y/R/P set per accepted strobe, walks 4 motors x 4 terms
// through one shared add/sub+clamp unit, then publishes all four motor
// rates on a single edge. Arming and a link watchdog keep the motors at
// MOTOR_MIN unless the controller is armed and being fed.
module pid_mixer_sequencer #(
  parameter int RATE_BIT_WIDTH       = 36,
  parameter int MOTOR_RATE_BIT_WIDTH = 16,
  parameter int MOTOR_MIN            = 0,
  parameter int MOTOR_MAX            = 1000,
  parameter int WDOG_CYCLES          = 1000000
) (
  input  logic                            sys_clk,
  input  logic                            rst,
  input  logic                            arm,
  input  logic                            rates_valid,
  input  logic [RATE_BIT_WIDTH-1:0]       throttle_rate,
  input  logic [RATE_BIT_WIDTH-1:0]       yaw_rate,
  input  logic [RATE_BIT_WIDTH-1:0]       roll_rate,
  input  logic [RATE_BIT_WIDTH-1:0]       pitch_rate,
  output logic                            rates_ready,
  output logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_1_rate,
  output logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_2_rate,
  output logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_3_rate,
  output logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_4_rate,
  output logic                            motor_valid,
  output logic                            armed,
  output logic                            wdog_fault
);

  import pid_mixer_sequencer_pkg::*;

  localparam int RBW   = RATE_BIT_WIDTH;
  localparam int MBW   = MOTOR_RATE_BIT_WIDTH;
  localparam int STEPS = NUM_MOTORS * MIX_TERMS;
  localparam int WDW   = $clog2(WDOG_CYCLES + 1);
  localparam logic [MBW-1:0] MIN_M = MBW'(MOTOR_MIN);

  mix_state_t r_state;
  mix_state_t w_next_state;

  logic [3:0]                      r_step;
  logic [WDW-1:0]                  r_wdog;
  logic [RBW-1:0]                  r_cap_t;
  logic [RBW-1:0]                  r_cap_y;
  logic [RBW-1:0]                  r_cap_r;
  logic [RBW-1:0]                  r_cap_p;
  logic [NUM_MOTORS-1:0][MBW-1:0]  r_stage;
  logic [NUM_MOTORS-1:0][MBW-1:0]  r_motor;
  logic                            r_valid;
  logic                            r_armed;
  logic                            r_fault;
  logic                            r_ready;

  logic           w_thr_nonpos;
  logic           w_accept;
  logic           w_expire;
  logic           w_publish;
  logic           w_force_min;
  logic           w_mix_en;
  logic           w_load;
  logic           w_sub;
  logic [1:0]     w_motor;
  logic [1:0]     w_term;
  logic [RBW-1:0] w_operand;
  logic [MBW-1:0] w_clamped;

  // Event decode: arming condition, strobe acceptance and watchdog expiry.
  always_comb begin
    w_thr_nonpos = throttle_rate[RBW-1] | (throttle_rate == {RBW{1'b0}});
    w_accept     = (r_state == ST_IDLE) && arm && rates_valid;
    w_expire     = (r_wdog == WDW'(WDOG_CYCLES - 1));
  end

  // Next-state logic; disarm beats strobe accept, which beats expiry.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_DISARMED: begin
        if (rates_valid && arm && w_thr_nonpos) w_next_state = ST_IDLE;
        else                                    w_next_state = ST_DISARMED;
      end
      ST_IDLE: begin
        if (!arm)             w_next_state = ST_DISARMED;
        else if (rates_valid) w_next_state = ST_MIX;
        else if (w_expire)    w_next_state = ST_FAULT;
        else                  w_next_state = ST_IDLE;
      end
      ST_MIX: begin
        if (!arm)                        w_next_state = ST_DISARMED;
        else if (w_expire)               w_next_state = ST_FAULT;
        else if (r_step == 4'(STEPS-1))  w_next_state = ST_PUBLISH;
        else                             w_next_state = ST_MIX;
      end
      ST_PUBLISH: begin
        if (!arm)          w_next_state = ST_DISARMED;
        else if (w_expire) w_next_state = ST_FAULT;
        else               w_next_state = ST_IDLE;
      end
      ST_FAULT: begin
        if (!arm) w_next_state = ST_DISARMED;
        else      w_next_state = ST_FAULT;
      end
      default: w_next_state = ST_DISARMED;
    endcase
  end

  // Output-side control derived from the upcoming state.
  always_comb begin
    w_publish   = (r_state == ST_PUBLISH) && (w_next_state == ST_IDLE);
    w_force_min = (w_next_state == ST_DISARMED) || (w_next_state == ST_FAULT);
  end

  // Drive the shared unit: term 0 loads throttle, terms 1..3 add/subtract.
  always_comb begin
    w_mix_en = (r_state == ST_MIX);
    w_motor  = r_step[3:2];
    w_term   = r_step[1:0];
    w_load   = (w_term == 2'd0);
    if (w_term == 2'd0) begin
      w_sub = 1'b0;
    end else begin
      w_sub = SIGN_TABLE[w_motor][w_term - 2'd1];
    end
    case (w_term)
      2'd0:    w_operand = r_cap_t;
      2'd1:    w_operand = r_cap_y;
      2'd2:    w_operand = r_cap_r;
      2'd3:    w_operand = r_cap_p;
      default: w_operand = r_cap_t;
    endcase
  end

  mixer_addsub_clamp #(
    .RBW       (RBW),
    .MBW       (MBW),
    .MOTOR_MIN (MOTOR_MIN),
    .MOTOR_MAX (MOTOR_MAX)
  ) u_addsub (
    .clk       (sys_clk),
    .rst       (rst),
    .i_en      (w_mix_en),
    .i_load    (w_load),
    .i_sub     (w_sub),
    .i_operand (w_operand),
    .o_clamped (w_clamped)
  );

  // FSM state register.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) r_state <= ST_DISARMED;
    else     r_state <= w_next_state;
  end

  // Capture the rate set on accept and restart the motor/term walk.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_cap_t <= '0;
      r_cap_y <= '0;
      r_cap_r <= '0;
      r_cap_p <= '0;
      r_step  <= 4'd0;
    end else if (w_accept) begin
      r_cap_t <= throttle_rate;
      r_cap_y <= yaw_rate;
      r_cap_r <= roll_rate;
      r_cap_p <= pitch_rate;
      r_step  <= 4'd0;
    end else if (r_state == ST_MIX) begin
      r_step  <= r_step + 4'd1;
    end else begin
      r_step  <= r_step;
    end
  end

  // Link watchdog: runs while armed, cleared by any accepted strobe.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_wdog <= '0;
    end else if (is_armed_state(r_state) && !w_accept) begin
      r_wdog <= r_wdog + WDW'(1);
    end else begin
      r_wdog <= '0;
    end
  end

  // Staging: the clamped sum lands in slot m on its last term.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_stage <= '0;
    end else if (w_mix_en && (w_term == 2'd3)) begin
      r_stage[w_motor] <= w_clamped;
    end else begin
      r_stage <= r_stage;
    end
  end

  // Registered outputs: forced low when leaving the armed set, atomic
  // copy of all four staged values on publish.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_motor <= {NUM_MOTORS{MIN_M}};
      r_valid <= 1'b0;
      r_armed <= 1'b0;
      r_fault <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      if (w_force_min)    r_motor <= {NUM_MOTORS{MIN_M}};
      else if (w_publish) r_motor <= r_stage;
      else                r_motor <= r_motor;
      r_valid <= w_publish;
      r_armed <= is_armed_state(w_next_state);
      r_fault <= (w_next_state == ST_FAULT);
      r_ready <= (w_next_state == ST_DISARMED) || (w_next_state == ST_IDLE);
    end
  end

  assign motor_1_rate = r_motor[0];
  assign motor_2_rate = r_motor[1];
  assign motor_3_rate = r_motor[2];
  assign motor_4_rate = r_motor[3];
  assign motor_valid  = r_valid;
  assign armed        = r_armed;
  assign wdog_fault   = r_fault;
  assign rates_ready  = r_ready;

endmodule

// File: tb/tb_pid_mixer_sequencer.sv
// Self-checking bench for pid_mixer_sequencer: directed scenarios followed
// by randomized traffic, all compared every cycle against a transaction-level
// model (mix equations, 17-cycle latency, arm/watchdog rules).
module tb_pid_mixer_sequencer;

  localparam int RBW  = 36;
  localparam int MBW  = 16;
  localparam int MMIN = 0;
  localparam int MMAX = 1000;
  localparam int WDOG = 64;
  localparam int LAT  = 17;

  localparam int MD_DIS  = 0;
  localparam int MD_RDY  = 1;
  localparam int MD_BUSY = 2;
  localparam int MD_FLT  = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           arm;
  logic           rates_valid;
  logic [RBW-1:0] throttle_rate, yaw_rate, roll_rate, pitch_rate;
  logic           rates_ready;
  logic [MBW-1:0] motor_1_rate, motor_2_rate, motor_3_rate, motor_4_rate;
  logic           motor_valid, armed, wdog_fault;

  int n_checks = 0;
  int n_fail   = 0;
  int n_vpulse = 0;

  // model state
  int     m_mode;
  int     m_busy;
  int     m_since;
  longint m_pend [4];
  longint m_out  [4];
  bit     m_valid;

  pid_mixer_sequencer #(
    .RATE_BIT_WIDTH       (RBW),
    .MOTOR_RATE_BIT_WIDTH (MBW),
    .MOTOR_MIN            (MMIN),
    .MOTOR_MAX            (MMAX),
    .WDOG_CYCLES          (WDOG)
  ) dut (
    .sys_clk       (clk),
    .rst           (rst),
    .arm           (arm),
    .rates_valid   (rates_valid),
    .throttle_rate (throttle_rate),
    .yaw_rate      (yaw_rate),
    .roll_rate     (roll_rate),
    .pitch_rate    (pitch_rate),
    .rates_ready   (rates_ready),
    .motor_1_rate  (motor_1_rate),
    .motor_2_rate  (motor_2_rate),
    .motor_3_rate  (motor_3_rate),
    .motor_4_rate  (motor_4_rate),
    .motor_valid   (motor_valid),
    .armed         (armed),
    .wdog_fault    (wdog_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic longint sx(input logic [RBW-1:0] v);
    longint r;
    r = $signed(v);
    return r;
  endfunction

  function automatic longint clampm(input longint s);
    if (s < MMIN) return MMIN;
    if (s > MMAX) return MMAX;
    return s;
  endfunction

  task automatic model_reset();
    m_mode  = MD_DIS;
    m_busy  = 0;
    m_since = 0;
    m_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_out[i]  = MMIN;
      m_pend[i] = MMIN;
    end
  endtask

  // One clock edge of the reference behaviour, using the sampled inputs.
  task automatic model_edge();
    longint t, y, r, p;
    t = sx(throttle_rate); y = sx(yaw_rate); r = sx(roll_rate); p = sx(pitch_rate);
    m_valid = 1'b0;
    if (m_mode == MD_DIS) begin
      if (rates_valid && arm && t <= 0) begin
        m_mode  = MD_RDY;
        m_since = 0;
      end
    end else if (!arm) begin
      m_mode = MD_DIS;
      m_busy = 0;
      for (int i = 0; i < 4; i++) m_out[i] = MMIN;
    end else if (m_mode == MD_FLT) begin
      m_mode = MD_FLT;
    end else if (m_mode == MD_RDY && rates_valid) begin
      m_pend[0] = clampm(t - y + r + p);
      m_pend[1] = clampm(t + y - r + p);
      m_pend[2] = clampm(t - y - r - p);
      m_pend[3] = clampm(t + y + r - p);
      m_mode  = MD_BUSY;
      m_busy  = LAT;
      m_since = 0;
    end else begin
      m_since++;
      if (m_since == WDOG) begin
        m_mode = MD_FLT;
        for (int i = 0; i < 4; i++) m_out[i] = MMIN;
      end else if (m_mode == MD_BUSY) begin
        m_busy--;
        if (m_busy == 0) begin
          for (int i = 0; i < 4; i++) m_out[i] = m_pend[i];
          m_valid = 1'b1;
          m_mode  = MD_RDY;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("motor1", motor_1_rate, m_out[0]);
    chk("motor2", motor_2_rate, m_out[1]);
    chk("motor3", motor_3_rate, m_out[2]);
    chk("motor4", motor_4_rate, m_out[3]);
    chk("motor_valid", motor_valid, m_valid);
    chk("armed", armed, (m_mode == MD_RDY || m_mode == MD_BUSY) ? 1 : 0);
    chk("wdog_fault", wdog_fault, (m_mode == MD_FLT) ? 1 : 0);
    chk("rates_ready", rates_ready, (m_mode == MD_DIS || m_mode == MD_RDY) ? 1 : 0);
  endtask

  task automatic cycle(input bit a, input bit v, input longint t, input longint y,
                       input longint r, input longint p);
    @(negedge clk);
    arm = a; rates_valid = v;
    throttle_rate = RBW'(t); yaw_rate = RBW'(y); roll_rate = RBW'(r); pitch_rate = RBW'(p);
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    if (motor_valid) n_vpulse++;
  endtask

  task automatic idle(input int n, input bit a);
    for (int i = 0; i < n; i++) cycle(a, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic chk_motors(input string tag, input longint e1, input longint e2,
                            input longint e3, input longint e4);
    chk({tag, "_m1"}, motor_1_rate, e1);
    chk({tag, "_m2"}, motor_2_rate, e2);
    chk({tag, "_m3"}, motor_3_rate, e3);
    chk({tag, "_m4"}, motor_4_rate, e4);
  endtask

  function automatic longint rnd_rate(input bit throttle);
    logic [RBW-1:0] wide;
    if ($urandom_range(0, 19) == 0) begin
      wide = RBW'({$urandom(), $urandom()});
      return sx(wide);
    end
    if (throttle) return longint'($urandom_range(0, 1300)) - 200;
    return longint'($urandom_range(0, 600)) - 300;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int quiet;
    rst = 1'b1; arm = 1'b0; rates_valid = 1'b0;
    throttle_rate = '0; yaw_rate = '0; roll_rate = '0; pitch_rate = '0;
    model_reset();
    #3;
    compare_all();
    chk("reset_armed", armed, 0);
    chk("reset_ready", rates_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // 1: arm with zero throttle
    cycle(1, 1, 0, 0, 0, 0);
    chk("t1_armed", armed, 1);
    chk("t1_ready", rates_ready, 1);

    // 2: basic mix, 17-cycle latency
    cycle(1, 1, 500, 10, 20, 30);
    chk("t2_busy", rates_ready, 0);
    idle(LAT - 1, 1);
    chk("t2_not_early", motor_valid, 0);
    idle(1, 1);
    chk("t2_valid", motor_valid, 1);
    chk_motors("t2", 540, 520, 440, 500);

    // 3: upper clamp, then lower clamp
    cycle(1, 1, 990, 0, 50, 50);
    idle(LAT, 1);
    chk_motors("t3a", 1000, 990, 890, 990);
    cycle(1, 1, -100, 0, 0, 0);
    idle(LAT, 1);
    chk_motors("t3b", 0, 0, 0, 0);

    // 4: second strobe while busy is dropped
    n_vpulse = 0;
    cycle(1, 1, 300, 5, 5, 5);
    idle(4, 1);
    cycle(1, 1, 700, 1, 1, 1);
    idle(LAT, 1);
    chk("t4_one_pulse", n_vpulse, 1);
    chk_motors("t4", 305, 305, 285, 305);

    // 5: disarm mid-MIX aborts, T>0 cannot re-arm
    n_vpulse = 0;
    cycle(1, 1, 600, 0, 0, 0);
    idle(7, 1);
    cycle(0, 0, 0, 0, 0, 0);
    chk_motors("t5_abort", 0, 0, 0, 0);
    chk("t5_armed", armed, 0);
    idle(12, 0);
    chk("t5_no_pulse", n_vpulse, 0);
    cycle(1, 1, 200, 0, 0, 0);
    chk("t5_rearm_pos", armed, 0);

    // 6: watchdog expiry, fault exit, async reset mid-MIX
    cycle(1, 1, 0, 0, 0, 0);
    idle(WDOG - 1, 1);
    chk("t6_before_exp", wdog_fault, 0);
    idle(1, 1);
    chk("t6_fault", wdog_fault, 1);
    cycle(1, 1, 400, 0, 0, 0);
    chk("t6_ignored", armed, 0);
    chk_motors("t6", 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("t6_fault_clr", wdog_fault, 0);
    cycle(1, 1, -5, 0, 0, 0);
    cycle(1, 1, 300, 0, 0, 0);
    idle(LAT, 1);
    chk_motors("t6_pre_rst", 300, 300, 300, 300);
    cycle(1, 1, 800, 0, 0, 0);
    idle(5, 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    chk_motors("t6_async_rst", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic
    quiet = 0;
    for (int i = 0; i < 3000; i++) begin
      bit a, v;
      a = ($urandom_range(0, 149) != 0);
      if (quiet > 0) begin
        v = 1'b0;
        quiet--;
      end else begin
        v = ($urandom_range(0, 4) == 0);
        if ($urandom_range(0, 299) == 0) quiet = WDOG + 16;
      end
      cycle(a, v, rnd_rate(1'b1), rnd_rate(1'b0), rnd_rate(1'b0), rnd_rate(1'b0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
